unified_mem_arbiter: RTL

Shares one single-port synchronous memory between the pipeline's instruction-fetch port and its data (MEM-stage) port. This replaces the separate instruction and data memories with one RAM. The block holds a two-way round-robin arbiter and a small issue/wait/respond state machine. Each requester sees a req/ready handshake, and the pipeline stalls its stage while req=1 and ready=0.

---
 rtl/unified_mem_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: lets the instruction-fetch port and the data port share
// one single-port synchronous RAM. A two-way round-robin arbiter picks a
// requester in IDLE. The access is then strobed once, the block waits out the
// memory latency, and the result is returned as a one-cycle ready pulse.
module unified_mem_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int MEM_LATENCY = 1   // must be >= 1
) (
    input  logic            clk,
    input  logic            reset,
    // instruction fetch port
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic [DW-1:0]   i_rdata,
    output logic            i_ready,
    // data (MEM stage) port
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_be,
    output logic [DW-1:0]   d_rdata,
    output logic            d_ready,
    // shared memory port
    output logic            mem_en,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_be,
    input  logic [DW-1:0]   mem_rdata,
    output logic            busy
);

    // The counter only has to reach MEM_LATENCY-1.
    localparam int            CW       = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;            // wait cycles elapsed after the strobe cycle
    logic          grantData;      // 1: access in flight belongs to the data port
    logic          lastGrantData;  // 1: most recent grant went to the data port
    logic          anyReq;
    logic          pickData;

    // Arbitration: a lone requester wins; on a tie, the port not served last wins.
    always_comb begin
        anyReq   = i_req | d_req;
        pickData = (i_req && d_req) ? ~lastGrantData : d_req;
    end

    // Issue/wait/respond sequencer. All outputs are registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            grantData     <= 1'b0;
            lastGrantData <= 1'b0;
            mem_en        <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_be        <= '0;
            i_rdata       <= '0;
            i_ready       <= 1'b0;
            d_rdata       <= '0;
            d_ready       <= 1'b0;
            busy          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (anyReq) begin
                        state         <= BUSY;
                        busy          <= 1'b1;
                        mem_en        <= 1'b1;
                        cnt           <= '0;
                        grantData     <= pickData;
                        lastGrantData <= pickData;
                        if (pickData) begin
                            mem_we    <= d_we;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            mem_be    <= d_be;
                        end else begin
                            // Fetches are always reads with no byte lanes enabled.
                            mem_we    <= 1'b0;
                            mem_addr  <= i_addr;
                            mem_be    <= '0;
                        end
                    end
                end

                BUSY: begin
                    mem_en <= 1'b0;
                    // The strobe cycle itself is not counted; read data lands
                    // MEM_LATENCY cycles after it, so capture on the last wait cycle.
                    if (!mem_en) begin
                        if (cnt == CNT_LAST) begin
                            state <= RESP;
                            if (grantData) begin
                                d_ready <= 1'b1;
                                if (!mem_we) begin
                                    d_rdata <= mem_rdata;
                                end
                            end else begin
                                i_ready <= 1'b1;
                                i_rdata <= mem_rdata;
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end

                RESP: begin
                    // The finished requester still holds req this cycle, so no
                    // grant is made here; the next decision happens in IDLE.
                    i_ready <= 1'b0;
                    d_ready <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
